// File: rtl/fir3_mac_core.sv
// 3-tap FIR datapath and controller: one shared multiplier evaluates
// y = h0*x[n] + h1*x[n-1] + h2*x[n-2] over three MAC cycles per accepted sample.
module fir3_mac_core #(
  parameter int unsigned DATAWIDTH     = 16,
  parameter int unsigned PRODUCT_WIDTH = 2 * DATAWIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATAWIDTH-1:0]     x_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [DATAWIDTH-1:0]     h0,
  input  logic [DATAWIDTH-1:0]     h1,
  input  logic [DATAWIDTH-1:0]     h2,
  output logic [PRODUCT_WIDTH-1:0] y_out,
  output logic                     ld_y,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, DONE} state_t;

  state_t state_q, state_d;

  logic signed [DATAWIDTH-1:0] x0_q, x1_q, x2_q;
  logic signed [DATAWIDTH-1:0] h0_q, h1_q, h2_q;
  logic signed [DATAWIDTH-1:0] mul_a, mul_b;
  logic [PRODUCT_WIDTH-1:0]    acc_q, prod, mac_sum;
  logic                        accept;

  // Shared signed multiplier; accumulation wraps modulo 2^PRODUCT_WIDTH
  assign prod    = PRODUCT_WIDTH'(mul_a) * PRODUCT_WIDTH'(mul_b);
  assign mac_sum = acc_q + prod;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mul_a   = h2_q;
    mul_b   = x2_q;
    case (state_q)
      IDLE: begin
        if (x_valid && x_ready) begin
          accept  = 1'b1;
          state_d = MAC0;
        end
      end
      MAC0: begin
        mul_a   = h0_q;
        mul_b   = x0_q;
        state_d = MAC1;
      end
      MAC1: begin
        mul_a   = h1_q;
        mul_b   = x1_q;
        state_d = MAC2;
      end
      MAC2:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Delay line and coefficient latches move only on an accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
      h0_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
    end else if (accept) begin
      x2_q <= x1_q;
      x1_q <= x0_q;
      x0_q <= x_in;
      h0_q <= h0;
      h1_q <= h1;
      h2_q <= h2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      y_out <= '0;
    end else begin
      case (state_q)
        MAC0:    acc_q <= prod;
        MAC1:    acc_q <= mac_sum;
        MAC2:    y_out <= mac_sum;
        default: ;
      endcase
    end
  end

  // Handshake/status outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      x_ready <= 1'b1;
      busy    <= 1'b0;
      ld_y    <= 1'b0;
    end else begin
      x_ready <= (state_d == IDLE);
      busy    <= (state_d != IDLE);
      ld_y    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_fir3_mac_core.sv
// Scoreboard bench for fir3_mac_core: drivers push expected results and accept
// cycles, a negedge monitor pops and checks on every ld_y strobe.
module tb_fir3_mac_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x_in = '0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [15:0] h0 = '0, h1 = '0, h2 = '0;
  logic [31:0] y_out;
  logic        ld_y;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        prev_ld = 1'b0;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  fir3_mac_core #(.DATAWIDTH(16), .PRODUCT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .h0(h0), .h1(h1), .h2(h2), .y_out(y_out), .ld_y(ld_y), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: result order, accept-to-strobe latency, single-cycle strobe, busy/ready
  always @(negedge clk) begin
    if (ld_y) begin
      chk("ld_y_single_cycle", 32'(prev_ld), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ld_y", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("y_out", y_out, e);
        chk("latency", 32'(cyc - a), 32'd3);
      end
    end
    prev_ld = ld_y;
    if (!rst) chk("busy_vs_ready", 32'(busy), 32'(!x_ready));
  end

  task automatic do_reset();
    rst = 1'b1;
    x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_x_ready", 32'(x_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld_y", 32'(ld_y), 32'd0);
    chk("rst_y_out", y_out, 32'd0);
  endtask

  // Called at posedge+#1; waits (bounded) for x_ready, then offers one sample
  task automatic send(input int x, input int c0, input int c1, input int c2,
                      input logic [31:0] exp, input bit want);
    int n = 0;
    while (!x_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!x_ready) begin
      chk("send_timeout", 32'd1, 32'd0);
      return;
    end
    x_in = 16'(x);
    h0 = 16'(c0);
    h1 = 16'(c1);
    h2 = 16'(c2);
    x_valid = 1'b1;
    if (want) exp_q.push_back(exp);
    @(posedge clk); #1;
    if (want) acc_q.push_back(cyc);
    x_valid = 1'b0;
    h0 = 16'h5555;
    h1 = 16'h5555;
    h2 = 16'h5555;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int ex[4];
    logic [31:0] held;
    ex = '{10, 80, 260, 560};

    do_reset();

    // Impulse response
    send(1, 3, -5, 7, 32'd3, 1'b1);
    send(0, 3, -5, 7, 32'(-5), 1'b1);
    send(0, 3, -5, 7, 32'd7, 1'b1);
    send(0, 3, -5, 7, 32'd0, 1'b1);
    drain();

    // Step response (history is all zero after the impulse tail)
    for (int i = 0; i < 4; i++) begin
      logic [31:0] s[4];
      s = '{32'd100, 32'd300, 32'd600, 32'd600};
      send(100, 1, 2, 3, s[i], 1'b1);
    end
    drain();

    // Overflow corner wraps without saturation
    do_reset();
    send(-32768, -32768, -32768, -32768, 32'h4000_0000, 1'b1);
    send(-32768, -32768, -32768, -32768, 32'h8000_0000, 1'b1);
    send(-32768, -32768, -32768, -32768, 32'hC000_0000, 1'b1);
    drain();

    // Continuous x_valid: accepts every 5th cycle, junk coefficients while busy
    do_reset();
    for (int k = 0; k < 20; k++) begin
      chk("hs_x_ready", 32'(x_ready), 32'((k % 5) == 0));
      x_in = 16'(10 * (k + 1));
      if (x_ready) begin
        h0 = 16'd1; h1 = 16'd2; h2 = 16'd3;
        exp_q.push_back(32'(ex[k / 5]));
      end else begin
        h0 = 16'd9; h1 = 16'd9; h2 = 16'd9;
      end
      x_valid = 1'b1;
      @(posedge clk); #1;
      if ((k % 5) == 0) acc_q.push_back(cyc);
    end
    x_valid = 1'b0;
    drain();

    // Idle hold: no strobes, y_out and delay line untouched
    held = y_out;
    chk("idle_y_before", held, 32'd560);
    x_in = 16'h7777;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_y_after", y_out, 32'd560);
    send(0, 1, 2, 3, 32'd650, 1'b1);
    drain();

    // Reset during MAC1 discards the in-flight result
    send(5, 1, 1, 1, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_x_ready", 32'(x_ready), 32'd1);
    chk("midrst_ld_y", 32'(ld_y), 32'd0);
    chk("midrst_y_out", y_out, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    send(1, 1, 1, 1, 32'd1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
